inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Parametrised instruction fetch unit that owns the fetch PC, issues single-outstanding read requests to the ICache, and buffers returned instructions with their PCs in a DEPTH-entry FIFO toward the decode/issue stage. Next PC comes from the branch predictor. Flush from the flow controller redirects the PC, empties the FIFO and discards any in-flight ICache response. It sits between the ICache, the predictor and the processor front end, with valid/ready output and backpressure.

## Interface
- ADDR_W, 32, PC/address width
- INST_W, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset

- clk  in  1  system clock; all state changes on posedge
- rst  in  1  reset; asynchronous and active-high
- rdy  in  1  global ready; when low, all state holds and inputs are ignored
- pred_next_pc  in  ADDR_W  predictor's next PC for the current fetch_pc; combinational from fetch_pc
- fetch_pc  out  ADDR_W  PC of the current or next request, exposed to the predictor
- flush  in  1  redirect request from the flow controller
- flush_pc  in  ADDR_W  redirect target
- ic_req  out  1  ICache read request, held high until the response arrives
- ic_addr  out  ADDR_W  request address; equals fetch_pc while ic_req is high
- ic_resp_valid  in  1  one-cycle pulse; ic_resp_inst is valid
- ic_resp_inst  in  INST_W  returned instruction
- out_valid  out  1  FIFO non-empty
- out_inst  out  INST_W  head instruction
- out_pc  out  ADDR_W  head PC
- out_ready  in  1  consumer accepts the head when out_valid is high

## Operation
- State:
  - fetch_pc
  - ic_req
  - drop flag
  - FIFO of {pc, inst}
  - rd_ptr and wr_ptr, log2(DEPTH) bits, wrapping modulo DEPTH
  - count, log2(DEPTH)+1 bits
- pop = out_valid & out_ready.
- push = ic_resp_valid & ~drop & ~flush. A push writes {fetch_pc, ic_resp_inst} at wr_ptr.
- count_next = count + push − pop. Simultaneous push and pop at full or empty are both legal.
- On push:
  - fetch_pc ← pred_next_pc.
  - ic_req stays high next cycle iff count_next < DEPTH; otherwise it goes low.
- Refetch: while ic_req is low, drop is low and count < DEPTH, ic_req rises next cycle. A pop at full therefore re-enables fetch one cycle later.
- Only one request is outstanding at a time. ic_addr never changes while ic_req is high.
- Flush has priority over everything else in its cycle:
  - The FIFO empties: pointers and count go to 0, and that cycle's pop is ignored.
  - fetch_pc ← flush_pc.
  - If ic_req is high and ic_resp_valid is low, drop ← 1 and ic_req ← 0.
  - Otherwise ic_req ← 1 next cycle, requesting flush_pc.
- With drop = 1:
  - The next ic_resp_valid is discarded and drop clears.
  - ic_req rises in the following cycle with the latest fetch_pc.
- A flush while drop = 1 keeps drop = 1 and overwrites fetch_pc; the last flush wins.
- rdy low freezes everything, including a pending flush (not latched).

## Timing
- Reset values:
  - fetch_pc = RESET_PC
  - ic_req = 0
  - drop = 0
  - count = 0
  - out_valid = 0
  - out_inst = 0 and out_pc = 0 (head entry contents are cleared)
- ic_req rises at the first posedge after rst deasserts, with ic_addr = RESET_PC.
- Response to FIFO: a push at edge t gives out_valid at t+1 when the FIFO was empty. There is no bypass.
- Back-to-back ICache with zero-cycle response: one instruction per cycle.
- Flush at edge t: out_valid = 0 after t; earliest new ic_req is after t, or one cycle after the dropped response.
- rst asserted mid-operation: all state resets immediately and asynchronously; any response still pending is ignored because ic_req = 0.

## Test plan
- Reset release, ICache answers one cycle after each request, out_ready = 1, predictor returns pc+4 → requests to 0x0, 0x4, 0x8…; outputs (0x0, I0), (0x4, I1) in order.
- out_ready = 0, DEPTH = 4 → exactly 4 pushes, then ic_req low; raise out_ready for one cycle → ic_req high next cycle; no entry lost or duplicated.
- Flush to 0x100 while a request to 0x8 is outstanding → 0x8 response discarded; next ic_addr = 0x100; out_valid low until the 0x100 instruction is pushed.
- Flush coincident with ic_resp_valid and out_ready → response not pushed, no pop counted, count = 0, ic_req high next cycle at flush_pc.
- Two flushes (0x200, then 0x300) while drop is set → single discard; next request 0x300.
- rdy low for 3 cycles mid-stream with ic_resp_valid pulses → no state change; resumes identically afterward.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch PC owner with a single-outstanding ICache request and a DEPTH-entry {pc, inst} FIFO.
// Ports:
//   clk, rst (async active-high), rdy (global hold when low)
//   pred_next_pc (in)  / fetch_pc (out)   : predictor loop for the current fetch PC
//   flush, flush_pc (in)                  : redirect, empties FIFO, drops an in-flight response
//   ic_req, ic_addr (out)                 : ICache request, held until the response arrives
//   ic_resp_valid, ic_resp_inst (in)      : one-cycle ICache response
//   out_valid, out_inst, out_pc (out), out_ready (in) : FIFO head toward decode
module inst_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pred_next_pc,
  output logic [ADDR_W-1:0] fetch_pc,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              ic_req,
  output logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_resp_valid,
  input  logic [INST_W-1:0] ic_resp_inst,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              ic_req_q, ic_req_d;
  logic              drop_q, drop_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d, count_nx;
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];
  logic              pop, push;
  // A response is only accepted while our own request is live, so anything
  // arriving after reset or during a drop window never enters the FIFO.
  assign pop      = rdy & (count_q != '0) & out_ready;
  assign push     = rdy & ic_resp_valid & ic_req_q & ~drop_q & ~flush;
  assign count_nx = count_q + CW'(push) - CW'(pop);
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    ic_req_d   = ic_req_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (rdy && flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = flush_pc;
      // A request still awaiting its response (fresh or already being dropped)
      // must be swallowed before the redirected fetch can go out.
      drop_d     = (ic_req_q | drop_q) & ~ic_resp_valid;
      ic_req_d   = ~drop_d;
    end else if (rdy) begin
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      count_d  = count_nx;
      if (push) begin
        pc_mem_d[wr_ptr_q]   = fetch_pc_q;
        inst_mem_d[wr_ptr_q] = ic_resp_inst;
        fetch_pc_d           = pred_next_pc;
        ic_req_d             = count_nx < CW'(DEPTH);
      end else if (drop_q) begin
        drop_d = ~ic_resp_valid;
      end else if (!ic_req_q) begin
        ic_req_d = count_q < CW'(DEPTH);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      ic_req_q   <= 1'b0;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      ic_req_q   <= ic_req_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end
  assign fetch_pc  = fetch_pc_q;
  assign ic_req    = ic_req_q;
  assign ic_addr   = fetch_pc_q;
  assign out_valid = count_q != '0;
  assign out_inst  = inst_mem_q[rd_ptr_q];
  assign out_pc    = pc_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: randomized and directed check of inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  logic        clk = 1'b0;
  logic        rst, rdy, flush, ic_resp_valid, out_ready;
  logic [31:0] flush_pc, ic_resp_inst, pred_next_pc;
  logic [31:0] fetch_pc, ic_addr, out_inst, out_pc;
  logic        ic_req, out_valid;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] m_fpc = 32'h0;
  logic        m_req = 1'b0;
  logic        m_drop = 1'b0;
  ent_t        q[$];
  always #5 clk = ~clk;
  function automatic logic [31:0] pred(input logic [31:0] pc);
    return pc[4] ? pc + 32'h40 : pc + 32'h4;
  endfunction
  assign pred_next_pc = pred(fetch_pc);
  inst_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pred_next_pc(pred_next_pc), .fetch_pc(fetch_pc),
    .flush(flush), .flush_pc(flush_pc), .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_inst(ic_resp_inst), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  task automatic model_step();
    int   n;
    logic pu;
    if (rst) begin
      m_fpc  = 32'h0;
      m_req  = 1'b0;
      m_drop = 1'b0;
      q.delete();
    end else if (rdy) begin
      n  = q.size();
      pu = ic_resp_valid && !m_drop && !flush;
      if (flush) begin
        q.delete();
        m_fpc = flush_pc;
        if ((m_req || m_drop) && !ic_resp_valid) begin
          m_drop = 1'b1;
          m_req  = 1'b0;
        end else begin
          m_drop = 1'b0;
          m_req  = 1'b1;
        end
      end else begin
        if (out_ready && n > 0) void'(q.pop_front());
        if (pu) q.push_back('{m_fpc, ic_resp_inst});
        if (m_drop) begin
          if (ic_resp_valid) m_drop = 1'b0;
        end else if (pu) begin
          m_fpc = pred(m_fpc);
          m_req = q.size() < DEPTH;
        end else if (!m_req && n < DEPTH) begin
          m_req = 1'b1;
        end
      end
    end
  endtask
  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("ic_req", ic_req, m_req);
      chk("fetch_pc", fetch_pc, m_fpc);
      if (m_req) chk("ic_addr", ic_addr, m_fpc);
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_pc", out_pc, q[0].pc);
        chk("out_inst", out_inst, q[0].inst);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; flush_pc = 32'h0;
    out_ready = 1'b1; ic_resp_valid = 1'b0; ic_resp_inst = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ic_req", ic_req, 0);
    chk("rst_fetch_pc", fetch_pc, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_pc", out_pc, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("pre_first_edge_req", ic_req, 0);
    cyc();
    chk("first_req", ic_req, 1);
    chk("first_addr", ic_addr, 32'h0);
    ic_resp_valid = 1'b1; ic_resp_inst = 32'hA0;
    cyc();
    chk("a_out_valid", out_valid, 1);
    chk("a_out_pc0", out_pc, 32'h0);
    chk("a_out_inst0", out_inst, 32'hA0);
    chk("a_addr4", ic_addr, 32'h4);
    ic_resp_inst = 32'hA1;
    cyc();
    chk("a_out_pc1", out_pc, 32'h4);
    chk("a_out_inst1", out_inst, 32'hA1);
    chk("a_addr8", ic_addr, 32'h8);
    out_ready = 1'b0;
    repeat (8) begin
      ic_resp_valid = m_req || m_drop;
      ic_resp_inst = $urandom;
      cyc();
    end
    chk("b_full_req_low", ic_req, 0);
    chk("b_full_model_count", q.size(), DEPTH);
    chk("b_head_kept", out_pc, 32'h4);
    ic_resp_valid = 1'b0; out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("b_req_after_pop", ic_req, 0);
    cyc();
    chk("b_refetch", ic_req, 1);
    flush = 1'b1; flush_pc = 32'h100;
    cyc();
    chk("c_flush_empty", out_valid, 0);
    chk("c_flush_req_low", ic_req, 0);
    flush = 1'b0; ic_resp_valid = 1'b1; ic_resp_inst = 32'hDEAD;
    cyc();
    ic_resp_valid = 1'b0;
    chk("c_dropped_req_low", ic_req, 0);
    chk("c_dropped_not_pushed", out_valid, 0);
    cyc();
    chk("c_req_100", ic_req, 1);
    chk("c_addr_100", ic_addr, 32'h100);
    chk("c_still_empty", out_valid, 0);
    ic_resp_valid = 1'b1; ic_resp_inst = 32'hB0;
    cyc();
    ic_resp_valid = 1'b0;
    chk("c_push_valid", out_valid, 1);
    chk("c_push_pc", out_pc, 32'h100);
    chk("c_push_inst", out_inst, 32'hB0);
    chk("c_next_addr", ic_addr, 32'h104);
    flush = 1'b1; flush_pc = 32'h180; ic_resp_valid = 1'b1; out_ready = 1'b1;
    cyc();
    flush = 1'b0; ic_resp_valid = 1'b0; out_ready = 1'b0;
    chk("d_empty", out_valid, 0);
    chk("d_req", ic_req, 1);
    chk("d_addr", ic_addr, 32'h180);
    flush = 1'b1; flush_pc = 32'h200;
    cyc();
    chk("e_drop1_req", ic_req, 0);
    flush_pc = 32'h300;
    cyc();
    chk("e_drop2_req", ic_req, 0);
    chk("e_last_flush_pc", fetch_pc, 32'h300);
    flush = 1'b0; ic_resp_valid = 1'b1;
    cyc();
    ic_resp_valid = 1'b0;
    chk("e_discard_req", ic_req, 0);
    chk("e_discard_empty", out_valid, 0);
    cyc();
    chk("e_req_300", ic_req, 1);
    chk("e_addr_300", ic_addr, 32'h300);
    ic_resp_valid = 1'b1; ic_resp_inst = 32'hC0;
    cyc();
    ic_resp_valid = 1'b0;
    chk("e_push_pc", out_pc, 32'h300);
    chk("e_push_inst", out_inst, 32'hC0);
    rdy = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ic_resp_valid = (i != 1);
      flush = (i == 1);
      flush_pc = 32'h40;
      ic_resp_inst = $urandom;
      cyc();
    end
    rdy = 1'b1; flush = 1'b0; ic_resp_valid = 1'b0; out_ready = 1'b0;
    chk("f_frozen_valid", out_valid, 1);
    chk("f_frozen_pc", out_pc, 32'h300);
    chk("f_frozen_addr", ic_addr, 32'h304);
    chk("f_frozen_req", ic_req, 1);
    cyc();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #3 rst = 1'b1;
        ic_resp_valid = 1'b0; flush = 1'b0;
        #1;
        chk("mid_rst_req", ic_req, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_pc", fetch_pc, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
      end
      rdy = $urandom_range(0, 7) != 0;
      flush = $urandom_range(0, 15) == 0;
      flush_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      out_ready = $urandom_range(0, 3) != 0;
      ic_resp_valid = (m_req || m_drop) && ($urandom_range(0, 1) == 1);
      ic_resp_inst = $urandom;
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
